ldpc_parity_accumulator: RTL and testbench

Accumulates the LDPC parity vector from the H1 row stream. It sits directly downstream of the H1 row loader. Each cycle it takes 27 rows of `LDPC_PARITY_SIZE` bits plus the 27 message bits aligned to them, and XORs in the rows whose message bit is 1. After 19 beats (27 × 19 = 513 message bits) it emits one parity vector with a one-cycle valid pulse, then restarts immediately for back-to-back blocks.

---
 rtl/ldpc_parity_accumulator.sv | 132 +++++++++++++
 tb/tb_ldpc_parity_accumulator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_parity_accumulator.sv
// ldpc_parity_accumulator
// Folds the H1 row stream into one LDPC parity vector per codeword. Each beat
// brings ROWS_PER_BEAT rows plus the message bits aligned to them. Every row
// whose message bit is set is XORed into a running accumulator. After
// BEATS_PER_BLOCK beats the finished vector is published with a one-cycle
// valid pulse. The next block may start on the very next cycle.
module ldpc_parity_accumulator #(
  parameter int LDPC_PARITY_SIZE = 162,
  parameter int ROWS_PER_BEAT    = 27,
  parameter int BEATS_PER_BLOCK  = 19
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_H,
  input  logic [LDPC_PARITY_SIZE-1:0] h_rows [ROWS_PER_BEAT-1:0],
  input  logic [ROWS_PER_BEAT-1:0]    msg_bits,
  output logic [LDPC_PARITY_SIZE-1:0] parity_out,
  output logic                        parity_valid,
  output logic                        busy,
  output logic [4:0]                  beat_idx,
  output logic                        abort
);

  // Index of the final beat of a codeword; the beat counter wraps here.
  localparam logic [4:0] LAST_BEAT = 5'(BEATS_PER_BLOCK - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // XOR of every row whose select bit is set. Masking by replication keeps
  // the reduction branch-free.
  function automatic logic [LDPC_PARITY_SIZE-1:0] masked_row_xor(
    input logic [LDPC_PARITY_SIZE-1:0] rows [ROWS_PER_BEAT-1:0],
    input logic [ROWS_PER_BEAT-1:0]    sel
  );
    logic [LDPC_PARITY_SIZE-1:0] acc;
    acc = '0;
    for (int j = 0; j < ROWS_PER_BEAT; j++) begin
      acc = acc ^ (rows[j] & {LDPC_PARITY_SIZE{sel[j]}});
    end
    return acc;
  endfunction

  state_e                      state_q;
  logic [LDPC_PARITY_SIZE-1:0] acc_q;
  logic [LDPC_PARITY_SIZE-1:0] parity_q;
  logic                        parity_valid_q;
  logic                        abort_q;
  logic                        busy_q;
  logic [4:0]                  beat_q;
  logic [LDPC_PARITY_SIZE-1:0] partial;
  logic [LDPC_PARITY_SIZE-1:0] acc_next;

  // Contribution of the current beat, plus the accumulator updated with it.
  always_comb begin
    partial  = masked_row_xor(h_rows, msg_bits);
    acc_next = acc_q ^ partial;
  end

  // Block FSM. It also drives every registered output.
  // Pulse outputs default low and are raised only on the cycle that ends a
  // block, either by completing it or by aborting it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      parity_q       <= '0;
      parity_valid_q <= 1'b0;
      abort_q        <= 1'b0;
      busy_q         <= 1'b0;
      beat_q         <= 5'd0;
    end else begin
      parity_valid_q <= 1'b0;
      abort_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_H) begin
            // Beat 0 seeds the accumulator directly. Nothing stale carries over.
            acc_q   <= partial;
            beat_q  <= 5'd1;
            busy_q  <= 1'b1;
            state_q <= ST_ACCUM;
          end else begin
            acc_q   <= '0;
            beat_q  <= 5'd0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (!valid_H) begin
            // The stream stopped mid-block. Drop the partial work and keep
            // the last published parity.
            acc_q   <= '0;
            beat_q  <= 5'd0;
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (beat_q == LAST_BEAT) begin
            parity_q       <= acc_next;
            parity_valid_q <= 1'b1;
            acc_q          <= '0;
            beat_q         <= 5'd0;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
            acc_q   <= acc_next;
            beat_q  <= beat_q + 5'd1;
            busy_q  <= 1'b1;
            state_q <= ST_ACCUM;
          end
        end
        default: begin
          // Unreachable encoding. Recover to a clean idle.
          acc_q   <= '0;
          beat_q  <= 5'd0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign parity_out   = parity_q;
  assign parity_valid = parity_valid_q;
  assign abort        = abort_q;
  assign busy         = busy_q;
  assign beat_idx     = beat_q;

endmodule

// File: tb/tb_ldpc_parity_accumulator.sv
// Scoreboard bench for ldpc_parity_accumulator. The driver feeds beats and
// updates a message-level reference model. The model stores the whole
// 513-bit message and its rows by global index. It computes parity as the XOR
// of the rows whose message bit is set. Expected completions and aborts are
// queued, and a negedge monitor pops and compares them whenever the DUT
// pulses.
module tb_ldpc_parity_accumulator;

  localparam int W     = 162;
  localparam int R     = 27;
  localparam int B     = 19;
  localparam int NMSG  = R * B;

  typedef struct {
    bit          is_abort;
    logic [W-1:0] par;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          valid_H;
  logic [W-1:0]  h_rows [R-1:0];
  logic [R-1:0]  msg_bits;
  logic [W-1:0]  parity_out;
  logic          parity_valid;
  logic          busy;
  logic [4:0]    beat_idx;
  logic          abort;

  int checks;
  int errors;

  exp_t          exp_q[$];
  logic [W-1:0]  m_rows [NMSG];
  bit            m_msg  [NMSG];
  int            m_beats;
  logic [W-1:0]  m_last;

  ldpc_parity_accumulator #(
    .LDPC_PARITY_SIZE(W),
    .ROWS_PER_BEAT(R),
    .BEATS_PER_BLOCK(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_H(valid_H),
    .h_rows(h_rows),
    .msg_bits(msg_bits),
    .parity_out(parity_out),
    .parity_valid(parity_valid),
    .busy(busy),
    .beat_idx(beat_idx),
    .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_row();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: compare against the scoreboard and the model state.
  always @(negedge clk) begin
    exp_t e;
    check_bit("pulse_exclusive", {4'd0, parity_valid & abort}, 5'd0);
    if (parity_valid || abort) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got pv=%0b ab=%0b want none", parity_valid, abort);
      end else begin
        e = exp_q.pop_front();
        check_bit("pulse_kind_abort", {4'd0, abort}, {4'd0, e.is_abort});
        check_bit("pulse_kind_valid", {4'd0, parity_valid}, {4'd0, ~e.is_abort});
        if (!e.is_abort) check_vec("block_parity", parity_out, e.par);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse got none want abort=%0b", e.is_abort);
    end
    check_bit("beat_idx", beat_idx, 5'(m_beats));
    check_bit("busy", {4'd0, busy}, {4'd0, (m_beats != 0)});
    check_vec("parity_hold", parity_out, m_last);
  end

  // Reference model: what the DUT should do on the edge that just happened.
  task automatic model_edge();
    logic [W-1:0] p;
    exp_t e;
    if (valid_H) begin
      for (int j = 0; j < R; j++) begin
        m_msg[m_beats * R + j]  = msg_bits[j];
        m_rows[m_beats * R + j] = h_rows[j];
      end
      m_beats++;
      if (m_beats == B) begin
        p = '0;
        for (int i = 0; i < NMSG; i++) if (m_msg[i]) p = p ^ m_rows[i];
        e.is_abort = 1'b0;
        e.par = p;
        exp_q.push_back(e);
        m_last = p;
        m_beats = 0;
      end
    end else if (m_beats != 0) begin
      e.is_abort = 1'b1;
      e.par = '0;
      exp_q.push_back(e);
      m_beats = 0;
    end
  endtask

  task automatic step(input logic v);
    valid_H = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_rows();
    for (int j = 0; j < R; j++) h_rows[j] = rand_row();
  endtask

  task automatic rand_beat();
    rand_rows();
    msg_bits = R'({$urandom} & 32'h07FF_FFFF);
  endtask

  task automatic rand_block();
    for (int b = 0; b < B; b++) begin
      rand_beat();
      step(1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_parity_out"}, parity_out, '0);
    check_bit({tag, "_parity_valid"}, {4'd0, parity_valid}, 5'd0);
    check_bit({tag, "_abort"}, {4'd0, abort}, 5'd0);
    check_bit({tag, "_busy"}, {4'd0, busy}, 5'd0);
    check_bit({tag, "_beat_idx"}, beat_idx, 5'd0);
  endtask

  initial begin
    logic [W-1:0] c3;
    logic [W-1:0] ca5;
    checks   = 0;
    errors   = 0;
    m_beats  = 0;
    m_last   = '0;
    rst      = 1'b0;
    valid_H  = 1'b0;
    msg_bits = '0;
    rand_rows();
    c3  = W'(3);
    ca5 = W'(8'hA5);

    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    step(1'b0);

    // All-zero message.
    for (int b = 0; b < B; b++) begin
      rand_rows();
      msg_bits = '0;
      step(1'b1);
    end
    step(1'b0);
    check_vec("all_zero_parity", parity_out, '0);

    // Single message bit, row 0 of beat 0.
    for (int b = 0; b < B; b++) begin
      rand_rows();
      if (b == 0) begin
        h_rows[0] = c3;
        msg_bits  = R'(1);
      end else begin
        msg_bits = '0;
      end
      step(1'b1);
    end
    step(1'b0);
    check_vec("single_bit_parity", parity_out, c3);

    // All-ones message on constant rows. The count is odd, so the row survives.
    for (int b = 0; b < B; b++) begin
      for (int j = 0; j < R; j++) h_rows[j] = ca5;
      msg_bits = '1;
      step(1'b1);
    end
    step(1'b0);
    check_vec("all_ones_parity", parity_out, ca5);

    // Back-to-back random blocks with no bubble.
    rand_block();
    rand_block();
    step(1'b0);
    step(1'b0);

    // Drop after beat 10, then a clean block.
    for (int b = 0; b <= 10; b++) begin
      rand_beat();
      step(1'b1);
    end
    step(1'b0);
    check_bit("drop_beat_idx", beat_idx, 5'd0);
    rand_block();
    step(1'b0);

    // Async reset mid-block, between clock edges.
    for (int b = 0; b < 7; b++) begin
      rand_beat();
      step(1'b1);
    end
    valid_H = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_beats = 0;
    m_last  = '0;
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    step(1'b0);
    rand_block();
    step(1'b0);

    // Random traffic with occasional drops.
    for (int n = 0; n < 150; n++) begin
      rand_beat();
      step(($urandom % 40) != 0);
    end
    step(1'b0);
    step(1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
